// File: rtl/spi_adc_responder_pkg.sv
// Shared servo-link constants and the ADC responder state encoding.
//
// Contents:
//   ADC_DATA_W, ADC_LEAD_ZEROS, FRAME_W : frame geometry shared with the SPI master
//   adc_state_e                         : responder FSM state encoding
package spi_adc_responder_pkg;

  // Frame geometry the master and the responder agree on.
  localparam int unsigned ADC_DATA_W     = 12;
  localparam int unsigned ADC_LEAD_ZEROS = 4;
  localparam int unsigned FRAME_W        = ADC_LEAD_ZEROS + ADC_DATA_W;

  // Master-side timing minimum, in system clock periods, for a given synchronizer depth.
  localparam int unsigned SCK_MIN_HALF_EXTRA = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLoad   = 2'd1,
    StShift  = 2'd2,
    StWaitHi = 2'd3
  } adc_state_e;

endpackage

// File: rtl/spi_adc_responder_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous input.
//
// Ports:
//   clock  in  system clock
//   reset  in  synchronous active-high reset
//   din    in  asynchronous input pin
//   level  out synchronized level, time-aligned with rise/fall
//   rise   out one-cycle pulse on a synchronized rising edge (registered)
//   fall   out one-cycle pulse on a synchronized falling edge (registered)
//
// rise/fall appear STAGES+1 cycles after the pin edge.
module spi_adc_responder_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;
  logic              rise_q;
  logic              fall_q;
  logic              sync_out;

  assign sync_out = sync_q[STAGES-1];

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_out;
      rise_q <= sync_out & ~hist_q;
      fall_q <= ~sync_out & hist_q;
    end
  end

  // hist_q updates on the same edge as rise_q/fall_q, so it is the level matching the pulses.
  assign level = hist_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/spi_adc_responder.sv
// SPI responder acting as the ADC on the servo feedback link.
// Each frame shifts out LEAD_ZEROS zero bits then a DATA_W-bit sample, MSB first;
// miso changes after synchronized sck falling edges so the master samples on sck rise.
//
// Ports:
//   clock        in  system clock
//   reset        in  synchronous active-high reset
//   cs_n         in  chip select, active low, asynchronous
//   sck          in  serial clock, idle low, asynchronous
//   sample       in  value to transmit, captured at frame start
//   miso         out serial data to the master
//   busy         out high from frame start until cs_n is seen high again
//   frame_done   out one-cycle pulse after the last bit has been shifted
//   sample_taken out one-cycle pulse when sample is captured
module spi_adc_responder
  import spi_adc_responder_pkg::*;
#(
  parameter int unsigned DATA_W      = ADC_DATA_W,
  parameter int unsigned LEAD_ZEROS  = ADC_LEAD_ZEROS,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cs_n,
  input  logic              sck,
  input  logic [DATA_W-1:0] sample,
  output logic              miso,
  output logic              busy,
  output logic              frame_done,
  output logic              sample_taken
);

  localparam int unsigned FrameLen  = LEAD_ZEROS + DATA_W;
  localparam int unsigned CntW      = $clog2(FrameLen);
  localparam int unsigned SettleCnt = SYNC_STAGES + 2;

  logic cs_level, cs_rise, cs_fall;
  logic sck_level, sck_rise, sck_fall;
  logic unused_sync;

  spi_adc_responder_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b1)
  ) u_cs_sync_edge (
    .clock(clock),
    .reset(reset),
    .din  (cs_n),
    .level(cs_level),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  spi_adc_responder_sync_edge #(
    .STAGES   (SYNC_STAGES),
    .RESET_VAL(1'b0)
  ) u_sck_sync_edge (
    .clock(clock),
    .reset(reset),
    .din  (sck),
    .level(sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  // Master samples on sck rise; nothing here reacts to it. Exits key off the cs level.
  assign unused_sync = sck_level ^ sck_rise ^ cs_rise;

  adc_state_e           state_q, state_d;
  logic [FrameLen-1:0]  shreg_q, shreg_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 miso_q, miso_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 taken_q, taken_d;
  logic [2:0]           settle_q, settle_d;
  logic                 armed_q, armed_d;

  // The synchronizers reset to cs_n=1, so a cs_n pin held low through reset would look like a
  // fresh falling edge. Frames are only accepted once cs_n has really been seen high after the
  // synchronizer has flushed its reset value.
  always_comb begin
    settle_d = settle_q;
    if (settle_q != 3'(SettleCnt)) begin
      settle_d = settle_q + 3'd1;
    end
    armed_d = armed_q | ((settle_q == 3'(SettleCnt)) & cs_level);
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    miso_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    taken_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        if (cs_fall && armed_q) begin
          state_d = StLoad;
          shreg_d = {{LEAD_ZEROS{1'b0}}, sample};
          cnt_d   = CntW'(FrameLen - 1);
          taken_d = 1'b1;
          busy_d  = 1'b1;
          miso_d  = shreg_d[FrameLen-1];
        end
      end

      StLoad: begin
        if (cs_level) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else begin
          state_d = StShift;
          miso_d  = shreg_q[FrameLen-1];
        end
      end

      StShift: begin
        // Abort is checked first so it wins over a coincident sck fall.
        if (cs_level) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end else if (sck_fall) begin
          shreg_d = {shreg_q[FrameLen-2:0], 1'b0};
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = StWaitHi;
          end else begin
            cnt_d  = cnt_q - 1'b1;
            miso_d = shreg_d[FrameLen-1];
          end
        end else begin
          miso_d = shreg_q[FrameLen-1];
        end
      end

      StWaitHi: begin
        if (cs_level) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      shreg_q  <= '0;
      cnt_q    <= '0;
      miso_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      taken_q  <= 1'b0;
      settle_q <= '0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      miso_q   <= miso_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      taken_q  <= taken_d;
      settle_q <= settle_d;
      armed_q  <= armed_d;
    end
  end

  assign miso         = miso_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign sample_taken = taken_q;

endmodule

// File: tb/tb_spi_adc_responder.sv
// Directed bench for spi_adc_responder: a table of frames driven by a simple SPI master model,
// plus a hand-written reset-mid-frame sequence.
module tb_spi_adc_responder;

  localparam int S = 2;

  logic        clock;
  logic        reset;
  logic        cs_n;
  logic        sck;
  logic [11:0] sample;
  logic        miso;
  logic        busy;
  logic        frame_done;
  logic        sample_taken;

  spi_adc_responder #(
    .DATA_W     (12),
    .LEAD_ZEROS (4),
    .SYNC_STAGES(S)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cs_n        (cs_n),
    .sck         (sck),
    .sample      (sample),
    .miso        (miso),
    .busy        (busy),
    .frame_done  (frame_done),
    .sample_taken(sample_taken)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [11:0] smp;
    int          npulse;
    int          chg_at;
    logic [11:0] chg_val;
    logic [31:0] exp_word;
    int          exp_done;
  } vec_t;

  int checks = 0;
  int errors = 0;

  int done_cnt = 0;
  int taken_cnt = 0;
  int busy_cnt = 0;
  int done_at_pulse = 0;
  int pulse_idx = 0;

  always @(negedge clock) begin
    if (frame_done) begin
      done_cnt      <= done_cnt + 1;
      done_at_pulse <= pulse_idx;
    end
    if (sample_taken) taken_cnt <= taken_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int          t0;
    int          d0;
    int          first;
    logic [31:0] rx;
    rx        = '0;
    t0        = taken_cnt;
    d0        = done_cnt;
    pulse_idx = 0;
    first     = 0;
    sample    = v.smp;
    cs_n      = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      if (sample_taken && first == 0) first = i;
    end
    check($sformatf("v%0d taken_latency", idx), first, S + 2);
    for (int p = 1; p <= v.npulse; p++) begin
      pulse_idx = p;
      sck = 1'b1;
      rx  = {rx[30:0], miso};
      wait_cycles(10);
      sck = 1'b0;
      wait_cycles(10);
      if (p == v.chg_at) sample = v.chg_val;
    end
    check($sformatf("v%0d word", idx), rx, v.exp_word);
    check($sformatf("v%0d busy_before_cs_rise", idx), busy, 1);
    cs_n = 1'b1;
    wait_cycles(S + 2);
    check($sformatf("v%0d busy_after_cs_rise", idx), busy, 0);
    check($sformatf("v%0d miso_after_cs_rise", idx), miso, 0);
    wait_cycles(10);
    check($sformatf("v%0d taken_pulses", idx), taken_cnt - t0, 1);
    check($sformatf("v%0d done_pulses", idx), done_cnt - d0, v.exp_done);
    if (v.exp_done != 0) check($sformatf("v%0d done_after_pulse", idx), done_at_pulse, 16);
  endtask

  vec_t vecs[7];
  vec_t rst_followup;

  initial begin
    int t0;
    int d0;
    int b0;

    //            sample   pulses chg  chg_val  expected word   done
    vecs[0] = '{12'hA5C, 16,    0,   12'h000, 32'h0000_0A5C,  1};
    vecs[1] = '{12'hFFF, 16,    0,   12'h000, 32'h0000_0FFF,  1};
    vecs[2] = '{12'h000, 16,    0,   12'h000, 32'h0000_0000,  1};
    vecs[3] = '{12'h123, 16,    5,   12'hEEE, 32'h0000_0123,  1};
    vecs[4] = '{12'h7AB, 7,     0,   12'h000, 32'h0000_0003,  0};  // abort after 7 bits
    vecs[5] = '{12'h456, 16,    0,   12'h000, 32'h0000_0456,  1};
    vecs[6] = '{12'h9C3, 20,    0,   12'h000, 32'h0000_9C30,  1};  // 4 extra zero bits
    rst_followup = '{12'h3C5, 16, 0, 12'h000, 32'h0000_03C5, 1};

    reset  = 1'b1;
    cs_n   = 1'b1;
    sck    = 1'b0;
    sample = '0;
    wait_cycles(4);
    check("reset miso", miso, 0);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    check("reset sample_taken", sample_taken, 0);
    reset = 1'b0;
    wait_cycles(10);

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], i);
    end

    // Reset while the 9th sck pulse is high and cs_n is still low.
    sample = 12'hBBB;
    cs_n   = 1'b0;
    wait_cycles(10);
    for (int p = 1; p <= 8; p++) begin
      sck = 1'b1;
      wait_cycles(10);
      sck = 1'b0;
      wait_cycles(10);
    end
    sck = 1'b1;
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
    check("midreset miso", miso, 0);
    check("midreset busy", busy, 0);
    check("midreset frame_done", frame_done, 0);
    check("midreset sample_taken", sample_taken, 0);
    wait_cycles(1);
    reset = 1'b0;
    t0 = taken_cnt;
    d0 = done_cnt;
    b0 = busy_cnt;
    wait_cycles(5);
    sck = 1'b0;
    wait_cycles(10);
    for (int p = 1; p <= 6; p++) begin
      sck = 1'b1;
      wait_cycles(10);
      sck = 1'b0;
      wait_cycles(10);
    end
    check("post-reset no sample_taken", taken_cnt - t0, 0);
    check("post-reset no frame_done", done_cnt - d0, 0);
    check("post-reset no busy", busy_cnt - b0, 0);
    check("post-reset miso", miso, 0);
    cs_n = 1'b1;
    wait_cycles(10);
    run_frame(rst_followup, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_adc_responder.md
# spi_adc_responder

Synthesizable SPI responder that plays the ADC side of the servo feedback link. It answers the frame started by the chip-select generator and clocked by the SPI master: each frame shifts out a 16-bit word, four leading zeros and then a 12-bit sample, MSB first. It drives the serial data line that the servo top samples, so it serves both as a stand-in ADC for closed-loop bring-up on the board and as the bench model for the master.

## Interface
Parameters:
- `DATA_W`, 12, sample width in bits.
- `LEAD_ZEROS`, 4, zero bits sent before the sample; frame length `FRAME_W = LEAD_ZEROS + DATA_W` (16).
- `SYNC_STAGES`, 2, flip-flop stages on `cs_n` and `sck`; legal range 2..3.

Ports:
- `clock`, in, 1, system clock; all state changes on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `cs_n`, in, 1, chip select from the master, active low, asynchronous to `clock`.
- `sck`, in, 1, serial clock from the master, idle low, asynchronous to `clock`.
- `sample`, in, `DATA_W`, value to transmit; captured at frame start.
- `miso`, out, 1, serial data to the master.
- `busy`, out, 1, high from frame start until `cs_n` is seen high again.
- `frame_done`, out, 1, one-cycle pulse after the last bit has been shifted.
- `sample_taken`, out, 1, one-cycle pulse when `sample` is captured.

## Operation
- `cs_n` and `sck` each pass through `SYNC_STAGES` flops, then one history flop. Edges are detected on the synchronized signals only.
- The state machine has four states: IDLE, LOAD, SHIFT, WAIT_HI.
- IDLE: `miso`=0 and `busy`=0. A synchronized falling edge on `cs_n` moves to LOAD.
- LOAD (one cycle):
  - shift register ← {`LEAD_ZEROS`'b0, `sample`}.
  - bit counter ← `FRAME_W`-1.
  - Pulse `sample_taken` and set `busy`=1.
  - `miso` = shift register MSB (a leading zero). Go to SHIFT.
- SHIFT:
  - Each synchronized `sck` falling edge shifts the register left by one and fills with 0. `miso` always shows the current MSB.
  - The counter decrements on each falling edge.
  - On the falling edge that occurs with counter = 0, pulse `frame_done`, force `miso`=0 and go to WAIT_HI.
  - `sck` rising edges change nothing (the master samples on them).
- WAIT_HI: `miso`=0. Extra `sck` edges are ignored. A synchronized `cs_n` high returns the block to IDLE with `busy`=0.
- Abort: `cs_n` seen high while in LOAD or SHIFT returns the block to IDLE next cycle. There is no `frame_done` pulse, `miso`=0, and the shift register is left as is.
- Simultaneous `cs_n` rise and `sck` fall in the same cycle: the abort wins.
- The sample is held for the whole frame; changes on `sample` during a frame do not affect `miso`.

## Timing
- Reset values: state IDLE, `miso`=0, `busy`=0, `frame_done`=0, `sample_taken`=0. Shift register, counter and synchronizers are all cleared; synchronizers are set to the idle values `cs_n`=1 and `sck`=0.
- Reset asserted mid-frame: IDLE on the next edge. A frame already in progress is not resumed, even if `cs_n` is still low.
- Edge-to-edge latency:
  - Pin edge to detection: `SYNC_STAGES`+1 cycles.
  - `miso` update: `SYNC_STAGES`+2 cycles after the `sck` falling pin edge.
  - `sample_taken` pulse: `SYNC_STAGES`+2 cycles after the `cs_n` falling pin edge.
- Legal master timing:
  - `sck` high and low times each ≥ `SYNC_STAGES`+3 `clock` periods.
  - First `sck` rise ≥ `SYNC_STAGES`+3 periods after `cs_n` falls.
- All outputs are registered.

## Structure
- Constants `FRAME_W` and the state encoding (2-bit enum IDLE=0, LOAD=1, SHIFT=2, WAIT_HI=3) go in the shared servo package, alongside the frame constants the master uses.
- One sub-module: `sync_edge`. It is instantiated twice (for `cs_n` and `sck`) and contains the parameterized synchronizer, the history flop and registered `rise`/`fall` outputs.

## Test plan
- Nominal frame: `sample`=12'hA5C, 16 `sck` pulses at 10 `clock` periods high/low. The master samples 16'h0A5C; `frame_done` pulses once, `busy` falls after `cs_n` rises.
- Full-scale values: `sample`=12'hFFF, then 12'h000. Received 16'h0FFF and 16'h0000; the first four bits are 0 in both frames.
- Sample change mid-frame: load 12'h123, switch `sample` to 12'hEEE after bit 5. Received word is 16'h0123.
- Abort: raise `cs_n` after 7 `sck` pulses. No `frame_done`, `miso`=0 and `busy`=0 within `SYNC_STAGES`+2 cycles. The next full frame with 12'h456 reads 16'h0456.
- Extra clocks: send 20 `sck` pulses. Bits 17–20 read 0; `frame_done` pulses exactly once, after pulse 16.
- Reset mid-frame: assert `reset` at bit 9 while `cs_n` stays low. All outputs return to reset values, and no frame starts until `cs_n` goes high and falls again.
